// File: rtl/sm_seq_pkg.sv
// Shared state encoding for the sequence monitor.
package sm_seq_pkg;

  // One-hot with an all-zero idle state.
  typedef enum logic [2:0] {
    StIdle  = 3'b000,
    StRun   = 3'b001,
    StDone  = 3'b010,
    StError = 3'b100
  } state_e;

endpackage

// File: rtl/sm_tmo_cnt.sv
// Inactivity counter: expire fires when the incremented count would reach a nonzero limit.
module sm_tmo_cnt #(
  parameter int unsigned TMO_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [TMO_W-1:0] limit,
  output logic             expire
);

  logic [TMO_W-1:0] cnt_q, cnt_d, cnt_inc;

  assign cnt_inc = cnt_q + TMO_W'(1);
  assign expire  = en && (limit != '0) && (cnt_inc == limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sm_seq_mon.sv
// Monitors a valid-qualified symbol stream against a DEPTH-step pattern, with repeat
// tolerance, inactivity timeout and a saturating error counter.
module sm_seq_mon
  import sm_seq_pkg::*;
#(
  parameter int unsigned W      = 2,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned TMO_W  = 8,
  parameter int unsigned ECNT_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [W-1:0]                 i,
  input  logic                         i_vld,
  input  logic [DEPTH*W-1:0]           seq_pat,
  input  logic [TMO_W-1:0]             tmo_limit,
  input  logic                         err_clr,
  output logic [$clog2(DEPTH+1)-1:0]   step,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         tmo,
  output logic [ECNT_W-1:0]            err_cnt
);

  localparam int unsigned SW = $clog2(DEPTH + 1);
  localparam logic [SW-1:0] LastStep = SW'(DEPTH - 1);
  localparam logic [SW-1:0] DoneStep = SW'(DEPTH);

  state_e            state_q, state_d;
  logic [SW-1:0]     step_q, step_d;
  logic              tmo_q, tmo_d;
  logic [ECNT_W-1:0] err_cnt_q, err_cnt_d;
  logic              busy_q, done_q, err_q;
  logic              adv, expire;

  // Pattern padded to a power-of-two table so any step index is in range.
  logic [W-1:0] sym [2**SW];
  for (genvar k = 0; k < 2**SW; k++) begin : g_sym
    if (k < DEPTH) begin : g_pat
      assign sym[k] = seq_pat[k*W +: W];
    end else begin : g_pad
      assign sym[k] = '0;
    end
  end

  sm_tmo_cnt #(
    .TMO_W (TMO_W)
  ) u_tmo_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    ((state_q != StRun) || adv),
    .en     (state_q == StRun),
    .limit  (tmo_limit),
    .expire (expire)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    tmo_d   = tmo_q;
    adv     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_vld && (i == sym[0])) begin
          state_d = StRun;
          step_d  = SW'(1);
        end else if (i_vld) begin
          state_d = StError;
          tmo_d   = 1'b0;
        end
      end
      StRun: begin
        // Advance is checked first so an equal previous symbol never holds.
        if (i_vld && (i == sym[step_q])) begin
          adv = 1'b1;
          if (step_q == LastStep) begin
            state_d = StDone;
            step_d  = DoneStep;
          end else begin
            step_d = step_q + SW'(1);
          end
        end else if (i_vld && (i != sym[step_q - SW'(1)])) begin
          state_d = StError;
          step_d  = '0;
          tmo_d   = 1'b0;
        end else if (expire) begin
          state_d = StError;
          step_d  = '0;
          tmo_d   = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        step_d  = '0;
      end
      StError: begin
        if (err_clr) begin
          state_d = StIdle;
          tmo_d   = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        step_d  = '0;
        tmo_d   = 1'b0;
      end
    endcase

    err_cnt_d = err_cnt_q;
    if ((state_d == StError) && (state_q != StError) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ECNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      step_q    <= '0;
      tmo_q     <= 1'b0;
      err_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      tmo_q     <= tmo_d;
      err_cnt_q <= err_cnt_d;
      busy_q    <= (state_d == StRun);
      done_q    <= (state_d == StDone);
      err_q     <= (state_d == StError);
    end
  end

  assign step    = step_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign tmo     = tmo_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_sm_seq_mon.sv
// Directed bench for sm_seq_mon with default parameters and pattern 11,01,10.
module tb_sm_seq_mon;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] i;
  logic       i_vld;
  logic [5:0] seq_pat;
  logic [7:0] tmo_limit;
  logic       err_clr;
  logic [1:0] step;
  logic       busy, done, err, tmo;
  logic [3:0] err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [5:0] PatMain = {2'b10, 2'b01, 2'b11};
  localparam logic [5:0] PatRep  = {2'b10, 2'b11, 2'b11};

  always #5 clk = ~clk;

  sm_seq_mon u_dut (
    .clk       (clk),
    .rst       (rst),
    .i         (i),
    .i_vld     (i_vld),
    .seq_pat   (seq_pat),
    .tmo_limit (tmo_limit),
    .err_clr   (err_clr),
    .step      (step),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .tmo       (tmo),
    .err_cnt   (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present inputs for one rising edge, then return 1 time unit after it.
  task automatic tick(input logic v, input logic [1:0] s, input logic c);
    i_vld   = v;
    i       = s;
    err_clr = c;
    @(posedge clk);
    #1;
    i_vld   = 1'b0;
    i       = 2'b00;
    err_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    rst = 1'b1; i = '0; i_vld = 1'b0; err_clr = 1'b0;
    seq_pat = PatMain; tmo_limit = 8'd4;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_step", step, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_errcnt", err_cnt, 0);
    rst = 1'b0;

    // Happy path
    tick(1, 2'b11, 0); check("hp_busy1", busy, 1); check("hp_step1", step, 1);
    tick(1, 2'b01, 0); check("hp_busy2", busy, 1); check("hp_step2", step, 2);
    tick(1, 2'b10, 0); check("hp_done", done, 1); check("hp_step3", step, 3);
    check("hp_busy3", busy, 0);
    tick(0, 2'b00, 0); check("hp_done_off", done, 0); check("hp_step0", step, 0);
    check("hp_errcnt", err_cnt, 0);

    // Repeat hold, then i_vld during DONE is ignored
    tick(1, 2'b11, 0);
    tick(1, 2'b11, 0); check("rep_hold_step", step, 1); check("rep_hold_err", err, 0);
    tick(1, 2'b11, 0); check("rep_hold_busy", busy, 1);
    tick(1, 2'b01, 0); check("rep_step2", step, 2);
    tick(1, 2'b10, 0); check("rep_done", done, 1);
    tick(1, 2'b11, 0); check("done_ign_busy", busy, 0); check("done_ign_done", done, 0);
    check("rep_errcnt", err_cnt, 0);

    // Bad symbol, ERROR persistence and clear
    tick(1, 2'b11, 0);
    tick(1, 2'b00, 0); check("bad_err", err, 1); check("bad_tmo", tmo, 0);
    check("bad_errcnt", err_cnt, 1); check("bad_busy", busy, 0);
    tick(1, 2'b11, 0); check("err_hold", err, 1); check("err_hold_cnt", err_cnt, 1);
    tick(0, 2'b00, 1); check("clr_err", err, 0); check("clr_step", step, 0);
    tick(0, 2'b00, 1); check("clr_idle_err", err, 0); check("clr_idle_busy", busy, 0);

    // Timeout after 4 idle cycles
    tick(1, 2'b11, 0);
    idle(3); check("tmo_pre_busy", busy, 1);
    idle(1); check("tmo_err", err, 1); check("tmo_flag", tmo, 1);
    check("tmo_errcnt", err_cnt, 2);
    tick(0, 2'b00, 1); check("tmo_clr", tmo, 0);

    // Repeats do not restart the timeout
    tick(1, 2'b11, 0);
    for (int k = 0; k < 3; k++) tick(1, 2'b11, 0);
    check("rtmo_pre_busy", busy, 1);
    tick(1, 2'b11, 0); check("rtmo_err", err, 1); check("rtmo_flag", tmo, 1);
    check("rtmo_errcnt", err_cnt, 3);
    tick(0, 2'b00, 1);

    // Advance wins over timeout in the expiry cycle
    tick(1, 2'b11, 0);
    idle(3);
    tick(1, 2'b01, 0); check("win_busy", busy, 1); check("win_step", step, 2);
    check("win_err", err, 0);
    idle(3);
    tick(1, 2'b10, 0); check("win_done", done, 1);
    tick(0, 2'b00, 0);

    // Limit 0 disables timeout
    tmo_limit = 8'd0;
    tick(1, 2'b11, 0);
    idle(100); check("nolim_busy", busy, 1); check("nolim_err", err, 0);
    tick(1, 2'b00, 0); check("nolim_exit_err", err, 1); check("nolim_errcnt", err_cnt, 4);
    tick(0, 2'b00, 1);
    tmo_limit = 8'd4;

    // err_clr in the detecting cycle does not block ERROR entry
    tick(1, 2'b00, 1); check("sim_clr_err", err, 1); check("sim_clr_cnt", err_cnt, 5);
    tick(0, 2'b00, 1);

    // Equal consecutive pattern steps must advance
    seq_pat = PatRep;
    tick(1, 2'b11, 0);
    tick(1, 2'b11, 0); check("eq_adv_step", step, 2);
    tick(1, 2'b10, 0); check("eq_adv_done", done, 1);
    tick(0, 2'b00, 0);
    seq_pat = PatMain;

    // Saturation: 12 more entries brings the total to 17
    for (int k = 0; k < 12; k++) begin
      tick(1, 2'b01, 0);
      tick(0, 2'b00, 1);
    end
    check("sat_errcnt", err_cnt, 4'hF);

    // Asynchronous reset mid-RUN
    tick(1, 2'b11, 0);
    tick(1, 2'b01, 0); check("rr_step_pre", step, 2);
    #2 rst = 1'b1;
    #1;
    check("rr_busy", busy, 0); check("rr_step", step, 0); check("rr_done", done, 0);
    check("rr_err", err, 0); check("rr_tmo", tmo, 0); check("rr_errcnt", err_cnt, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(1, 2'b11, 0); check("rr_re_step1", step, 1);
    tick(1, 2'b01, 0);
    tick(1, 2'b10, 0); check("rr_re_done", done, 1);
    tick(0, 2'b00, 0); check("rr_re_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sm_seq_mon.md
SM_SEQ_MON -- requirements
Module: sm_seq_mon

Interface
REQ-001 Parameter W, default 2, width of the monitored input symbol (W >= 1).
REQ-002 Parameter DEPTH, default 3, number of steps in the expected sequence (DEPTH >= 2).
REQ-003 Parameter TMO_W, default 8, width of the inactivity-timeout counter and limit.
REQ-004 Parameter ECNT_W, default 4, width of the error counter.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 i  input  W  input symbol, sampled only when i_vld=1.
REQ-008 i_vld  input  1  symbol-valid qualifier.
REQ-009 seq_pat  input  DEPTH*W  expected sequence, static while busy; step k at bits [k*W +: W].
REQ-010 tmo_limit  input  TMO_W  idle-cycle limit in RUN; 0 disables timeout.
REQ-011 err_clr  input  1  single-cycle request to leave ERROR.
REQ-012 step  output  clog2(DEPTH+1)  index of the next expected step.
REQ-013 busy  output  1  high while in RUN.
REQ-014 done  output  1  one-cycle pulse when the full sequence completes.
REQ-015 err  output  1  high while in ERROR.
REQ-016 tmo  output  1  high in ERROR when the error was caused by timeout.
REQ-017 err_cnt  output  ECNT_W  count of ERROR entries, saturating.

Function
REQ-018 The FSM SHALL use two always blocks: a registered current state and a combinational next-state block; outputs SHALL be registered (Moore, one-cycle latency from the deciding input).
REQ-019 States: IDLE, RUN, DONE, ERROR; the step index is a separate register.
REQ-020 IDLE: i_vld & i==pat[0] -> RUN with step=1; i_vld & i!=pat[0] -> ERROR; !i_vld -> IDLE.
REQ-021 RUN at step k: i_vld & i==pat[k] -> step=k+1, or DONE when k==DEPTH-1.
REQ-022 RUN at step k: i_vld & i==pat[k-1] (repeat of the previous symbol) -> hold; a repeat SHALL NOT restart the timeout.
REQ-023 RUN: i_vld with any other symbol -> ERROR, tmo=0.
REQ-024 If pat[k]==pat[k-1], the match SHALL advance, never hold.
REQ-025 Timeout counter: cleared on RUN entry and on each advancing match; increments each RUN cycle otherwise; when tmo_limit!=0 and the incremented value equals tmo_limit -> ERROR, tmo=1.
REQ-026 A valid advancing symbol in the timeout cycle SHALL win over the timeout.
REQ-027 DONE lasts exactly one cycle (done=1, step=DEPTH), then IDLE; i_vld during DONE is ignored.
REQ-028 ERROR: err=1; stays until err_clr=1 -> IDLE next cycle; i_vld ignored.
REQ-029 err_clr outside ERROR is ignored; err_clr in the same cycle an error is detected SHALL NOT prevent ERROR entry.
REQ-030 err_cnt increments by 1 on every transition into ERROR and saturates at all-ones.
REQ-031 step=0 in IDLE and ERROR.

Reset
REQ-032 While rst=1: state=IDLE, step=0, busy=0, done=0, err=0, tmo=0, err_cnt=0, timeout counter=0, all asynchronously.
REQ-033 Reset asserted mid-RUN or mid-ERROR SHALL abandon the sequence with no done pulse, and the first post-reset cycle behaves as IDLE.

Structure
REQ-034 Package sm_seq_pkg SHALL hold the state encoding: one-hot with zero idle, IDLE=3'b000, RUN=3'b001, DONE=3'b010, ERROR=3'b100.
REQ-035 The timeout counter SHALL be a sub-module sm_tmo_cnt (inputs clr, en, limit; output expire).

Verification (W=2, DEPTH=3, seq_pat: step0=11, step1=01, step2=10, tmo_limit=4)
REQ-036 Happy path: symbols 11,01,10 on consecutive cycles -> busy for 2 cycles, done=1 one cycle after the third symbol, then IDLE, err_cnt=0.
REQ-037 Repeat hold: symbols 11,11,11,01,10 -> no error, done pulses once.
REQ-038 Bad symbol: symbols 11,00 -> err=1, tmo=0, err_cnt=1; err_clr -> IDLE next cycle with err=0.
REQ-039 Timeout: symbol 11, then 4 cycles with i_vld=0 -> err=1, tmo=1; with tmo_limit=0, 100 idle cycles -> still busy.
REQ-040 Saturation: 17 error entries with ECNT_W=4 -> err_cnt=4'hF.
REQ-041 Reset in RUN after 11,01 -> all outputs 0 immediately; a following 11,01,10 completes normally.
